// File: rtl/spi_dev_lcdwr2_pkg.sv
// Shared types for the SPI-to-LCD write bridge: FSM states and FIFO entry layout.
package spi_dev_lcdwr2_pkg;

  localparam int unsigned ENTRY_W = 9;

  typedef enum logic [1:0] {
    ST_LEN0 = 2'd0,
    ST_LEN1 = 2'd1,
    ST_CMD  = 2'd2,
    ST_DATA = 2'd3
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

endpackage

// File: rtl/lcdwr2_fifo.sv
// Pointer-based synchronous FIFO holding {rs, data} entries for the LCD bridge.
module lcdwr2_fifo
  import spi_dev_lcdwr2_pkg::*;
#(
  parameter int unsigned LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [LOG2:0]      level
);

  localparam int unsigned DEPTH = 1 << LOG2;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [LOG2:0]      wptr;
  logic [LOG2:0]      rptr;
  logic               do_wr;
  logic               do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wptr[LOG2] != rptr[LOG2]) && (wptr[LOG2-1:0] == rptr[LOG2-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[LOG2-1:0]];
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr[LOG2-1:0]] <= wdata;
        wptr <= wptr + (LOG2+1)'(1);
      end
      if (do_rd) rptr <= rptr + (LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/spi_dev_lcdwr2.sv
// SPI-to-LCD write bridge: frames wrapper bytes into LCD cmd/data, buffers them, drains to PHY.
// Optional SPI_DEV_LCDWR2_OVF_CNT_EN adds a saturating dropped-byte counter port stat_ovf_cnt.
module spi_dev_lcdwr2
  import spi_dev_lcdwr2_pkg::*;
#(
  parameter logic [7:0]  CMD_BYTE  = 8'hf2,
  parameter int unsigned LEN_BYTES = 1,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [7:0]           phy_data,
  output logic                 phy_rs,
  output logic                 phy_valid,
  input  logic                 phy_ready,
  input  logic [7:0]           pw_wdata,
  input  logic                 pw_wcmd,
  input  logic                 pw_wstb,
  input  logic                 pw_end,
  output logic                 stat_ovf,
  input  logic                 stat_clr,
  output logic [FIFO_LOG2:0]   fifo_level,
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
  output logic [15:0]          stat_ovf_cnt,
`endif
  output logic                 busy
);

  localparam int unsigned LEN_W = 8 * LEN_BYTES;
  localparam int unsigned CNT_W = LEN_W + 1;

  lcd_state_e       state;
  logic             active;
  logic             inf;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len_val;
  logic             len_final;
  logic             last;
  logic             push_req;
  logic             ovf_set;
  logic             slot_load;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  lcd_entry_t       push_entry;
  lcd_entry_t       head;

  // Big-endian length; truncation keeps only the low byte in single-byte mode.
  assign len_val   = LEN_W'({len_hi, pw_wdata});
  assign len_final = (state == ST_LEN1) || ((state == ST_LEN0) && (LEN_BYTES == 1));
  // Counter runs one below the remaining count, so underflow into the MSB marks the final byte.
  assign last      = cnt[CNT_W-1] & ~inf;

  assign push_req   = pw_wstb & active & ~pw_wcmd & ((state == ST_CMD) || (state == ST_DATA));
  assign push_entry = '{rs: (state == ST_DATA), data: pw_wdata};
  assign ovf_set    = push_req & fifo_full;

  assign slot_load = ~phy_valid | phy_ready;
  assign pop       = slot_load & ~fifo_empty;

  assign busy = active | ~fifo_empty | phy_valid;

  lcdwr2_fifo #(
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (push_req),
    .wdata (push_entry),
    .rd_en (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Framing FSM; transaction end and command strobes always resynchronise to the length field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LEN0;
      active <= 1'b0;
      inf    <= 1'b0;
      cnt    <= '0;
      len_hi <= '0;
    end else if (pw_end) begin
      active <= 1'b0;
      state  <= ST_LEN0;
    end else if (pw_wstb) begin
      if (pw_wcmd) begin
        active <= (pw_wdata == CMD_BYTE);
        state  <= ST_LEN0;
      end else begin
        case (state)
          ST_LEN0, ST_LEN1: begin
            if (len_final) begin
              cnt   <= CNT_W'(len_val) - CNT_W'(1);
              inf   <= &len_val;
              state <= ST_CMD;
            end else begin
              len_hi <= pw_wdata;
              state  <= ST_LEN1;
            end
          end
          ST_CMD: begin
            cnt   <= cnt - CNT_W'(1);
            state <= last ? ST_LEN0 : ST_DATA;
          end
          ST_DATA: begin
            cnt <= cnt - CNT_W'(1);
            if (last) state <= ST_LEN0;
          end
        endcase
      end
    end
  end

  // Output skid slot: refills from the FIFO head whenever it is empty or being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phy_valid <= 1'b0;
      phy_data  <= '0;
      phy_rs    <= 1'b0;
    end else if (slot_load) begin
      phy_valid <= ~fifo_empty;
      if (!fifo_empty) begin
        phy_data <= head.data;
        phy_rs   <= head.rs;
      end
    end
  end

  // Sticky overflow flag; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovf <= 1'b0;
    end else if (ovf_set) begin
      stat_ovf <= 1'b1;
    end else if (stat_clr) begin
      stat_ovf <= 1'b0;
    end
  end

`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovf_cnt <= '0;
    end else if (stat_clr) begin
      stat_ovf_cnt <= ovf_set ? 16'd1 : 16'd0;
    end else if (ovf_set && (stat_ovf_cnt != 16'hffff)) begin
      stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_dev_lcdwr2.sv
// Bench for spi_dev_lcdwr2: two instances (1-byte length / depth 4, 2-byte length / depth 16)
// against a frame-level reference model and output scoreboards.
module tb_spi_dev_lcdwr2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: LEN_BYTES=1, FIFO_LOG2=2
  logic [7:0] a_pd, a_wdata;
  logic       a_rs, a_pv, a_ready, a_wcmd, a_wstb, a_end, a_ovf, a_clr, a_busy;
  logic [2:0] a_lvl;
  logic       a_rmode, a_rbit, a_rdir;
  // Instance B: LEN_BYTES=2, FIFO_LOG2=4
  logic [7:0] b_pd, b_wdata;
  logic       b_rs, b_pv, b_ready, b_wcmd, b_wstb, b_end, b_ovf, b_clr, b_busy;
  logic [4:0] b_lvl;
  logic       b_rmode, b_rbit, b_rdir;
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  assign a_ready = a_rmode ? a_rbit : a_rdir;
  assign b_ready = b_rmode ? b_rbit : b_rdir;

  spi_dev_lcdwr2 #(.CMD_BYTE(8'hf2), .LEN_BYTES(1), .FIFO_LOG2(2)) u_a (
    .clk(clk), .rst_n(rst_n), .phy_data(a_pd), .phy_rs(a_rs), .phy_valid(a_pv),
    .phy_ready(a_ready), .pw_wdata(a_wdata), .pw_wcmd(a_wcmd), .pw_wstb(a_wstb),
    .pw_end(a_end), .stat_ovf(a_ovf), .stat_clr(a_clr), .fifo_level(a_lvl),
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    .stat_ovf_cnt(a_cnt),
`endif
    .busy(a_busy));

  spi_dev_lcdwr2 #(.CMD_BYTE(8'hf2), .LEN_BYTES(2), .FIFO_LOG2(4)) u_b (
    .clk(clk), .rst_n(rst_n), .phy_data(b_pd), .phy_rs(b_rs), .phy_valid(b_pv),
    .phy_ready(b_ready), .pw_wdata(b_wdata), .pw_wcmd(b_wcmd), .pw_wstb(b_wstb),
    .pw_end(b_end), .stat_ovf(b_ovf), .stat_clr(b_clr), .fifo_level(b_lvl),
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    .stat_ovf_cnt(b_cnt),
`endif
    .busy(b_busy));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, indexed by instance
  int         lb[2]       = '{1, 2};
  bit         m_act[2];
  int         m_lenleft[2];
  int         m_lenacc[2];
  bit         m_incmd[2];
  int         m_dleft[2];
  int         m_len[2];
  int         budget[2]   = '{-1, -1};
  int         m_drops[2];
  bit         pace[2];
  int         n_out[2];
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always @(posedge clk) begin
    a_rbit <= ($urandom_range(0, 3) != 0);
    b_rbit <= ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, got, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic int lvl(input int d);
    return (d == 0) ? int'(a_lvl) : int'(b_lvl);
  endfunction

  function automatic void m_push(input int d, input logic [8:0] e);
    if (budget[d] == 0) begin
      m_drops[d]++;
      return;
    end
    if (budget[d] > 0) budget[d]--;
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endfunction

  function automatic void m_frame_reset(input int d);
    m_lenleft[d] = lb[d];
    m_lenacc[d]  = 0;
    m_incmd[d]   = 1'b0;
    m_dleft[d]   = 0;
  endfunction

  // Frame rules: length field, one LCD command, then L data bytes (all-ones length = stream).
  function automatic void m_byte(input int d, input bit c, input logic [7:0] v);
    if (c) begin
      m_act[d] = (v == 8'hf2);
      m_frame_reset(d);
    end else if (m_lenleft[d] > 0) begin
      m_lenacc[d] = m_lenacc[d] * 256 + int'(v);
      m_lenleft[d]--;
      if (m_lenleft[d] == 0) begin
        m_len[d]    = m_lenacc[d];
        m_lenacc[d] = 0;
        m_incmd[d]  = 1'b1;
      end
    end else if (m_incmd[d]) begin
      if (m_act[d]) m_push(d, {1'b0, v});
      m_incmd[d] = 1'b0;
      if (m_len[d] == 0) m_lenleft[d] = lb[d];
      else m_dleft[d] = (m_len[d] == (1 << (8 * lb[d])) - 1) ? -1 : m_len[d];
    end else begin
      if (m_act[d]) m_push(d, {1'b1, v});
      if (m_dleft[d] > 0) begin
        m_dleft[d]--;
        if (m_dleft[d] == 0) m_lenleft[d] = lb[d];
      end
    end
  endfunction

  task automatic check_pop(input int d, input logic [8:0] got);
    logic [8:0] exp;
    int sz;
    sz = qsize(d);
    n_out[d]++;
    chk("out_expected", d, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (d == 0) exp = qa.pop_front();
      else exp = qb.pop_front();
      chk("out_rs_data", d, 32'(got), 32'(exp));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_pv && a_ready) check_pop(0, {a_rs, a_pd});
      if (b_pv && b_ready) check_pop(1, {b_rs, b_pd});
    end
  end

  task automatic send(input int d, input bit c, input logic [7:0] v);
    int t;
    t = 0;
    if (pace[d]) begin
      while (lvl(d) >= ((d == 0) ? 2 : 12) && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
    end
    if (d == 0) begin a_wdata = v; a_wcmd = c; a_wstb = 1'b1; end
    else        begin b_wdata = v; b_wcmd = c; b_wstb = 1'b1; end
    m_byte(d, c, v);
    @(posedge clk); #1;
    a_wstb = 1'b0; a_wcmd = 1'b0;
    b_wstb = 1'b0; b_wcmd = 1'b0;
  endtask

  task automatic end_txn(input int d);
    if (d == 0) a_end = 1'b1;
    else b_end = 1'b1;
    m_act[d] = 1'b0;
    m_frame_reset(d);
    @(posedge clk); #1;
    a_end = 1'b0;
    b_end = 1'b0;
  endtask

  task automatic frame(input int d, input bit m, input int len, input int ninf, input bit cut);
    logic [7:0] cb;
    int nd;
    bit is_inf;
    cb = 8'($urandom_range(0, 255));
    if (cb == 8'hf2) cb = 8'h00;
    send(d, 1'b1, m ? 8'hf2 : cb);
    if (lb[d] == 2) send(d, 1'b0, 8'(len >> 8));
    send(d, 1'b0, 8'(len));
    send(d, 1'b0, 8'($urandom_range(0, 255)));
    is_inf = (len == (1 << (8 * lb[d])) - 1);
    nd = is_inf ? ninf : len;
    if (cut) nd = nd / 2;
    for (int i = 0; i < nd; i++) send(d, 1'b0, 8'($urandom_range(0, 255)));
    if (is_inf || cut) end_txn(d);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_queue_empty", d, 32'(qsize(d)), 32'd0);
    chk("drain_phy_valid", d, 32'((d == 0) ? a_pv : b_pv), 32'd0);
    chk("drain_level", d, 32'(lvl(d)), 32'd0);
  endtask

  task automatic rand_phase(input int d);
    int len;
    int r;
    int maxl;
    maxl = (1 << (8 * lb[d])) - 1;
    pace[d] = 1'b1;
    if (d == 0) a_rmode = 1'b1;
    else b_rmode = 1'b1;
    for (int f = 0; f < 25; f++) begin
      r = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? maxl : $urandom_range(1, 12);
      frame(d, ($urandom_range(0, 3) != 0), len, $urandom_range(0, 20), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) end_txn(d);
    end
    a_rmode = 1'b0;
    b_rmode = 1'b0;
    pace[d] = 1'b0;
    drain(d);
    chk("rand_no_overflow", d, 32'((d == 0) ? a_ovf : b_ovf), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    a_wdata = '0; a_wcmd = 0; a_wstb = 0; a_end = 0; a_clr = 0; a_rmode = 0; a_rdir = 1;
    b_wdata = '0; b_wcmd = 0; b_wstb = 0; b_end = 0; b_clr = 0; b_rmode = 0; b_rdir = 1;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_frame_reset(d); m_drops[d] = 0; pace[d] = 0; n_out[d] = 0;
    end

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_phy_valid", 0, 32'(a_pv), 32'd0);
    chk("rst_phy_data", 0, 32'(a_pd), 32'd0);
    chk("rst_phy_rs", 0, 32'(a_rs), 32'd0);
    chk("rst_stat_ovf", 0, 32'(a_ovf), 32'd0);
    chk("rst_level", 0, 32'(a_lvl), 32'd0);
    chk("rst_busy", 0, 32'(a_busy), 32'd0);
    chk("rst_phy_valid", 1, 32'(b_pv), 32'd0);
    chk("rst_busy", 1, 32'(b_busy), 32'd0);
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    chk("rst_ovf_cnt", 0, 32'(a_cnt), 32'd0);
`endif
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame plus two-edge latency, then a frame that reuses ST_LEN0 directly
    send(0, 1, 8'hf2); send(0, 0, 8'h03); send(0, 0, 8'h2a);
    chk("latency_k1_not_valid", 0, 32'(a_pv), 32'd0);
    send(0, 0, 8'h11);
    chk("latency_k2_valid", 0, 32'(a_pv), 32'd1);
    send(0, 0, 8'h22); send(0, 0, 8'h33);
    send(0, 0, 8'h01); send(0, 0, 8'h2b); send(0, 0, 8'h44);
    drain(0);

    // Zero length: next byte after command is a new length
    send(0, 1, 8'hf2); send(0, 0, 8'h00); send(0, 0, 8'h2c); send(0, 0, 8'h01); send(0, 0, 8'h2b);
    drain(0);

    // Infinite stream, then a non-matching transaction
    end_txn(0);
    n0 = n_out[0];
    send(0, 1, 8'hf2); send(0, 0, 8'hff); send(0, 0, 8'h2c);
    for (int i = 0; i < 300; i++) send(0, 0, 8'($urandom_range(0, 255)));
    end_txn(0);
    drain(0);
    chk("inf_out_count", 0, 32'(n_out[0] - n0), 32'd301);
    n0 = n_out[0];
    send(0, 1, 8'h5a); send(0, 0, 8'h02); send(0, 0, 8'h2d); send(0, 0, 8'h77); send(0, 0, 8'h78);
    drain(0);
    chk("inactive_no_output", 0, 32'(n_out[0] - n0), 32'd0);
    chk("inactive_busy", 0, 32'(a_busy), 32'd0);

    // Backpressure: 10 pushes into slot + depth-4 FIFO
    a_rdir = 1'b0;
    budget[0] = 5; m_drops[0] = 0;
    n0 = n_out[0];
    frame(0, 1'b1, 9, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_level", 0, 32'(a_lvl), 32'(5 - 1));
    chk("bp_stat_ovf", 0, 32'(a_ovf), 32'd1);
    chk("bp_busy", 0, 32'(a_busy), 32'd1);
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    chk("bp_ovf_cnt", 0, 32'(a_cnt), 32'(m_drops[0]));
`endif
    budget[0] = -1;
    a_rdir = 1'b1;
    drain(0);
    chk("bp_out_count", 0, 32'(n_out[0] - n0), 32'd5);

    // Two-byte length: 258 data bytes, then 2a is the next length high byte
    send(1, 1, 8'hf2); send(1, 0, 8'h01); send(1, 0, 8'h02); send(1, 0, 8'h2c);
    for (int i = 0; i < 258; i++) send(1, 0, 8'($urandom_range(0, 255)));
    send(1, 0, 8'h2a);
    repeat (3) @(posedge clk);
    #1;
    chk("len2_2a_not_forwarded", 1, 32'(qsize(1)), 32'd0);
    send(1, 0, 8'h00); send(1, 0, 8'h2b);
    drain(1);

    // Asynchronous reset with bytes queued and stat_ovf still set
    a_rdir = 1'b0;
    send(0, 1, 8'hf2); send(0, 0, 8'h03); send(0, 0, 8'h2a); send(0, 0, 8'h11); send(0, 0, 8'h22);
    @(posedge clk); #1;
    chk("pre_rst_level", 0, 32'(a_lvl), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_phy_valid", 0, 32'(a_pv), 32'd0);
    chk("async_rst_level", 0, 32'(a_lvl), 32'd0);
    chk("async_rst_stat_ovf", 0, 32'(a_ovf), 32'd0);
    chk("async_rst_busy", 0, 32'(a_busy), 32'd0);
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    chk("async_rst_ovf_cnt", 0, 32'(a_cnt), 32'd0);
`endif
    qa.delete(); qb.delete();
    for (int d = 0; d < 2; d++) begin m_act[d] = 0; m_frame_reset(d); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    a_rdir = 1'b1;

    // Overflow again, then clear
    a_rdir = 1'b0;
    budget[0] = 5; m_drops[0] = 0;
    frame(0, 1'b1, 6, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("clr_pre_ovf", 0, 32'(a_ovf), 32'd1);
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    chk("clr_pre_cnt", 0, 32'(a_cnt), 32'(m_drops[0]));
`endif
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("clr_post_ovf", 0, 32'(a_ovf), 32'd0);
`ifdef SPI_DEV_LCDWR2_OVF_CNT_EN
    chk("clr_post_cnt", 0, 32'(a_cnt), 32'd0);
`endif
    budget[0] = -1;
    a_rdir = 1'b1;
    drain(0);

    // Randomized frames with random PHY backpressure
    end_txn(0);
    end_txn(1);
    rand_phase(0);
    rand_phase(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
